pipe_scroller: RTL and testbench

Upstream stage that owns the scrolling pipe obstacles for the Flappy Bird playfield (columns 161..479).
- Keeps NUM_PIPES pipe positions and gap heights, scrolled once per video frame.
- Re-spawns pipes with LFSR-random gap heights.
- Drives is_pipe / is_pipe_edge and the pipe body/edge sprite ROM addresses consumed by the colour mapper.
- Emits a one-cycle pass_pulse to the score logic whenever a pipe clears the bird column.

---
 rtl/pipe_scroller.sv | 155 +++++++++++++++
 tb/tb_pipe_scroller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// Scrolling pipe obstacles: per-frame scroll, LFSR respawn, pass pulse, pixel/sprite decode.
// Pixel decode is zero-latency combinational; state updates on Clk; no backpressure.
module pipe_scroller #(
    parameter int NUM_PIPES = 2,
    parameter int PIPE_W    = 52,
    parameter int EDGE_H    = 24,
    parameter int GAP_H     = 100,
    parameter int SPACING   = 160,
    parameter int SPEED     = 2,
    parameter int SPAWN_X   = 480,
    parameter int GROUND_Y  = 400,
    parameter int BIRD_X    = 240
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        stop,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        is_pipe,
    output logic        is_pipe_edge,
    output logic [18:0] p_addr,
    output logic [18:0] p_e_addr,
    output logic        running,
    output logic        pass_pulse
);

    localparam logic signed [10:0] PW_S   = 11'(PIPE_W);
    localparam logic signed [10:0] EH_S   = 11'(EDGE_H);
    localparam logic signed [10:0] GH_S   = 11'(GAP_H);
    localparam logic signed [10:0] GY_S   = 11'(GROUND_Y);
    localparam logic signed [10:0] SPD_S  = 11'(SPEED);
    localparam logic signed [10:0] BX_S   = 11'(BIRD_X);
    localparam logic signed [10:0] LIM_S  = 11'sd161;
    localparam logic signed [10:0] WRAP_S = 11'(NUM_PIPES * SPACING);
    localparam logic [15:0]        LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    state_t                state_q;
    logic                  running_q, pass_q, frame_prev_q;
    logic [15:0]           lfsr_q, lfsr_d;
    logic signed [10:0]    x_q [NUM_PIPES];
    logic [7:0]            gap_q [NUM_PIPES];
    logic signed [10:0]    x_d [NUM_PIPES];
    logic [7:0]            gap_d [NUM_PIPES];
    logic signed [10:0]    nx [NUM_PIPES];
    logic                  cross_d;
    logic                  tick;
    logic [7:0]            rnd;

    assign tick       = frame_clk & ~frame_prev_q;
    assign running    = running_q;
    assign pass_pulse = pass_q;
    assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // Folding the top quarter down keeps gap_top within 64..255.
    assign rnd        = (lfsr_q[7:0] <= 8'd191) ? lfsr_q[7:0] : lfsr_q[7:0] - 8'd128;

    always_comb begin
        cross_d = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            nx[i]    = x_q[i] - SPD_S;
            x_d[i]   = nx[i];
            gap_d[i] = gap_q[i];
            if ((x_q[i] + PW_S > BX_S) && (nx[i] + PW_S <= BX_S))
                cross_d = 1'b1;
            if (nx[i] + PW_S <= LIM_S) begin
                x_d[i]   = nx[i] + WRAP_S;
                gap_d[i] = 8'd64 + rnd;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            running_q    <= 1'b0;
            pass_q       <= 1'b0;
            frame_prev_q <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i]   <= 11'(SPAWN_X + i * SPACING);
                gap_q[i] <= 8'd160;
            end
        end else begin
            frame_prev_q <= frame_clk;
            lfsr_q       <= lfsr_d;
            pass_q       <= 1'b0;
            case (state_q)
                RUN: begin
                    if (stop) begin
                        state_q   <= FROZEN;
                        running_q <= 1'b0;
                    end else if (tick) begin
                        x_q    <= x_d;
                        gap_q  <= gap_d;
                        pass_q <= cross_d;
                    end
                end
                default: begin
                    if (start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        lfsr_q    <= LFSR_SEED;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            x_q[i]   <= 11'(SPAWN_X + i * SPACING);
                            gap_q[i] <= 8'd160;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin : pixel_decode
        logic signed [10:0] dx, dy, gt, row;
        logic               hit;
        is_pipe      = 1'b0;
        is_pipe_edge = 1'b0;
        p_addr       = 19'd0;
        p_e_addr     = 19'd0;
        hit          = 1'b0;
        dx           = 11'sd0;
        gt           = 11'sd0;
        row          = 11'sd0;
        dy           = $signed({1'b0, DrawY});
        // First pipe whose columns cover DrawX owns the pixel.
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (!hit) begin
                dx = $signed({1'b0, DrawX}) - x_q[i];
                if (dx >= 11'sd0 && dx < PW_S) begin
                    hit = 1'b1;
                    gt  = $signed({3'b000, gap_q[i]});
                    if (dy < gt - EH_S) begin
                        is_pipe = 1'b1;
                        p_addr  = 19'(dx);
                    end else if (dy < gt) begin
                        is_pipe_edge = 1'b1;
                        row          = gt - 11'sd1 - dy;
                        p_e_addr     = 19'(row) * 19'(PIPE_W) + 19'(dx);
                    end else if (dy >= gt + GH_S && dy < gt + GH_S + EH_S) begin
                        is_pipe_edge = 1'b1;
                        row          = dy - (gt + GH_S);
                        p_e_addr     = 19'(row) * 19'(PIPE_W) + 19'(dx);
                    end else if (dy >= gt + GH_S + EH_S && dy < GY_S) begin
                        is_pipe = 1'b1;
                        p_addr  = 19'(dx);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized bench for pipe_scroller against an integer reference model of the playfield rules.
module tb_pipe_scroller;

    localparam int NP = 2;
    localparam int PW = 52;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0, start = 1'b0, stop = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        is_pipe, is_pipe_edge, running, pass_pulse;
    logic [18:0] p_addr, p_e_addr;

    pipe_scroller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .stop(stop),
        .DrawX(DrawX), .DrawY(DrawY), .is_pipe(is_pipe), .is_pipe_edge(is_pipe_edge),
        .p_addr(p_addr), .p_e_addr(p_e_addr), .running(running), .pass_pulse(pass_pulse)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0, n_err = 0;
    // Reference model: 0 idle, 1 run, 2 frozen
    int mstate, ml, mfp, mpass, mscrolls;
    int mx [NP];
    int mgap [NP];
    int pass_seen, last_pass_scroll;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_load();
        for (int i = 0; i < NP; i++) begin
            mx[i]   = 480 + i * 160;
            mgap[i] = 160;
        end
        ml       = 'hACE1;
        mscrolls = 0;
    endtask

    task automatic model_reset();
        model_load();
        mstate = 0; mfp = 0; mpass = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit fc);
        int nl, r, n;
        bit tk;
        tk    = fc && (mfp == 0);
        mfp   = fc;
        nl    = (ml >> 1) ^ (((ml & 1) != 0) ? 'hB400 : 0);
        mpass = 0;
        if (mstate != 1) begin
            if (st) begin
                model_load();
                nl     = 'hACE1;
                mstate = 1;
            end
        end else if (sp) begin
            mstate = 2;
        end else if (tk) begin
            r = ml & 'hFF;
            if (r > 191) r = r - 128;
            for (int i = 0; i < NP; i++) begin
                n = mx[i] - 2;
                if (mx[i] + PW > 240 && n + PW <= 240) mpass = 1;
                if (n + PW <= 161) begin
                    mx[i]   = n + NP * 160;
                    mgap[i] = 64 + r;
                end else begin
                    mx[i] = n;
                end
            end
            mscrolls++;
        end
        ml = nl;
    endtask

    task automatic model_pix(input int px, input int py,
                             output int ep, output int ee, output int pa, output int ea);
        int col, g;
        ep = 0; ee = 0; pa = 0; ea = 0;
        for (int i = 0; i < NP; i++) begin
            if (px >= mx[i] && px < mx[i] + PW) begin
                col = px - mx[i];
                g   = mgap[i];
                if (py < g - 24) begin ep = 1; pa = col; end
                else if (py < g) begin ee = 1; ea = (g - 1 - py) * PW + col; end
                else if (py >= g + 100 && py < g + 124) begin ee = 1; ea = (py - g - 100) * PW + col; end
                else if (py >= g + 124 && py < 400) begin ep = 1; pa = col; end
                break;
            end
        end
    endtask

    task automatic probe(input int px, input int py);
        int ep, ee, pa, ea;
        DrawX = 10'(px);
        DrawY = 10'(py);
        #1;
        model_pix(px, py, ep, ee, pa, ea);
        chk_val("is_pipe", is_pipe, ep);
        chk_val("is_pipe_edge", is_pipe_edge, ee);
        chk_val("p_addr", p_addr, pa);
        chk_val("p_e_addr", p_e_addr, ea);
        chk_val("flags_exclusive", is_pipe & is_pipe_edge, 0);
    endtask

    task automatic dprobe(input string tag, input int px, input int py,
                          input int ep, input int ee, input int pa, input int ea);
        DrawX = 10'(px);
        DrawY = 10'(py);
        #1;
        chk_val({tag, ".is_pipe"}, is_pipe, ep);
        chk_val({tag, ".is_pipe_edge"}, is_pipe_edge, ee);
        chk_val({tag, ".p_addr"}, p_addr, pa);
        chk_val({tag, ".p_e_addr"}, p_e_addr, ea);
    endtask

    task automatic step(input bit st, input bit sp, input bit fc);
        int k, px;
        start = st; stop = sp; frame_clk = fc;
        @(posedge Clk);
        model_step(st, sp, fc);
        #1;
        start = 1'b0; stop = 1'b0;
        chk_val("running", running, (mstate == 1) ? 1 : 0);
        chk_val("pass_pulse", pass_pulse, mpass);
        if (pass_pulse) begin
            pass_seen++;
            last_pass_scroll = mscrolls;
        end
        probe($urandom % 640, $urandom % 480);
        k  = $urandom % NP;
        px = mx[k] + $urandom_range(0, PW - 1);
        if (px < 0 || px > 1023) px = $urandom % 1024;
        probe(px, $urandom % 480);
    endtask

    task automatic frame();
        step(0, 0, 1);
        repeat ($urandom_range(1, 3)) step(0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        chk_val("reset.running", running, 0);
        chk_val("reset.pass", pass_pulse, 0);
        dprobe("reset.bird", 240, 50, 0, 0, 0, 0);
        dprobe("reset.pipe1", 645, 10, 1, 0, 5, 0);

        step(0, 0, 0);
        step(1, 0, 0);
        pass_seen = 0;
        repeat (10) frame();
        dprobe("scroll10.body", 470, 10, 1, 0, 10, 0);
        dprobe("scroll10.cap", 470, 150, 0, 1, 0, 478);

        guard = 0;
        while (mscrolls < 150 && guard < 500) begin frame(); guard++; end
        chk_val("reach150", mscrolls, 150);
        chk_val("pass_count", pass_seen, 1);
        chk_val("pass_tick", last_pass_scroll, 146);

        guard = 0;
        while (mscrolls < 185 && guard < 500) begin frame(); guard++; end
        dprobe("pre_respawn", 115, 10, 1, 0, 5, 0);
        frame();
        chk_val("reach186", mscrolls, 186);
        dprobe("vacated", 115, 10, 0, 0, 0, 0);
        dprobe("respawn.body", 433, 10, 1, 0, 5, 0);
        dprobe("respawn.cap", 433, mgap[0] - 1, 0, 1, 0, 5);

        step(0, 1, 0);
        repeat (5) frame();
        chk_val("frozen.running", running, 0);
        dprobe("frozen.visible", 433, 10, 1, 0, 5, 0);
        step(1, 0, 0);
        chk_val("restart.running", running, 1);
        dprobe("restart.reload", 485, 10, 1, 0, 5, 0);

        step(0, 1, 0);
        step(1, 0, 1);
        dprobe("start_tick.noscroll", 480, 10, 1, 0, 0, 0);
        step(0, 0, 0);
        frame();
        dprobe("first_scroll", 478, 10, 1, 0, 0, 0);
        step(1, 1, 0);
        chk_val("startstop.running", running, 0);
        step(1, 0, 0);
        repeat (3) frame();
        #1;
        Reset = 1'b1;
        #1;
        model_reset();
        chk_val("async_reset.running", running, 0);
        chk_val("async_reset.pass", pass_pulse, 0);
        dprobe("async_reset.pos", 485, 10, 1, 0, 5, 0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int c = 0; c < 1500; c++)
            step(($urandom % 60) == 0, ($urandom % 80) == 0, ($urandom % 3) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
